cmd_sequencer: RTL and testbench
================================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter CMD_W, default 2, width of command word.
REQ-002 Parameter CMD_FIRST, default 0, first command value issued after reset.
REQ-003 Parameter CMD_LAST, default 3, last command value before wrap; CMD_FIRST <= CMD_LAST < 2^CMD_W.
REQ-004 Parameter GAP_CYCLES, default 25000000, inter-command gap in clk cycles; legal range >= 1.
REQ-005 Parameter TIMER_W, default 25, gap/timeout counter width; must hold GAP_CYCLES and TIMEOUT_CYCLES.
REQ-006 Parameter TIMEOUT_CYCLES, default 1000, ready-wait limit; used only with the timeout feature.
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  run request; level-sensitive.
REQ-010 ready_command  input  1  downstream acknowledge of the current command.
REQ-011 command  output  CMD_W  current command word, registered.
REQ-012 start  output  1  one-cycle command-issue strobe, registered.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 cmd_count  output  16  count of acknowledged commands, wraps 65535->0.
REQ-015 timeout  output  1  one-cycle ready-wait timeout strobe.

Function
REQ-016 State machine SHALL have exactly four states: IDLE, SEND, WAIT_RDY, GAP.
REQ-017 IDLE: enable=1 sampled -> SEND next cycle; otherwise remain in IDLE.
REQ-018 SEND: start=1 for exactly this one cycle; next state WAIT_RDY unconditionally.
REQ-019 Latency: enable rising at edge k in IDLE -> start high during cycle k+1 to k+2.
REQ-020 WAIT_RDY: start=0; ready_command sampled only here; ready_command=1 during SEND is ignored.
REQ-021 WAIT_RDY with ready_command=1 -> GAP; same edge: cmd_count+1, command advances, timer loads GAP_CYCLES-1.
REQ-022 Command advance: command+1, except CMD_LAST -> CMD_FIRST (wrap).
REQ-023 command SHALL be stable from the SEND cycle until ready_command is accepted.
REQ-024 GAP: timer decrements each cycle; GAP occupies exactly GAP_CYCLES cycles.
REQ-025 GAP with timer=0: enable=1 -> SEND; enable=0 -> IDLE.
REQ-026 enable deasserted during SEND/WAIT_RDY/GAP: current command completes (ack and full gap), then IDLE.
REQ-027 Re-enable from IDLE resumes with the already-advanced command; no reset to CMD_FIRST.
REQ-028 busy SHALL be a registered decode of state, valid the same cycle the state is valid.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, command=CMD_FIRST, start=0, busy=0, cmd_count=0, timeout=0, timer=0.
REQ-030 rst asserted mid-operation SHALL abandon the outstanding command; no ack is counted.
REQ-031 First SEND after rst release requires enable=1 sampled in IDLE.

Configuration
REQ-032 Macro CMD_SEQ_TIMEOUT_EN defined: WAIT_RDY counts cycles; after TIMEOUT_CYCLES cycles without ready_command -> timeout=1 for one cycle, state GAP, command NOT advanced, cmd_count unchanged (same command re-issued after gap).
REQ-033 ready_command=1 in the cycle the limit is reached SHALL win: normal ack, timeout stays 0.
REQ-034 Macro undefined: WAIT_RDY waits indefinitely; timeout port present and tied to 0.

Verification (CMD_W=2, CMD_FIRST=1, CMD_LAST=3, GAP_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-035 Reset, enable=1, ready_command pulsed 2 cycles after each start -> commands 1,2,3,1,2; starts exactly 1+2+4=7 cycles apart; cmd_count=5.
REQ-036 enable dropped in WAIT_RDY of command 2 -> ack accepted, 4-cycle GAP, IDLE, busy=0, command=3; re-enable -> next start with command 3.
REQ-037 ready_command held 1 continuously -> SEND ignores it; ack in first WAIT_RDY cycle; start period 6 cycles.
REQ-038 rst pulsed in GAP and in WAIT_RDY -> outputs at reset values same cycle, command=1, cmd_count=0.
REQ-039 With CMD_SEQ_TIMEOUT_EN, no ready_command -> timeout pulse 8 cycles after WAIT_RDY entry, start re-issued with same command after 4-cycle gap; ready on cycle 8 -> no timeout, normal advance.
REQ-040 Without CMD_SEQ_TIMEOUT_EN, no ready_command for 10000 cycles -> remains in WAIT_RDY, busy=1, timeout=0.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Command sequencer: issues commands CMD_FIRST..CMD_LAST in rotation, waits for each ack, then idles for a gap.
// Optional ready-wait timeout compiled in with `define CMD_SEQ_TIMEOUT_EN.
module cmd_sequencer #(
  parameter int CMD_W          = 2,
  parameter int CMD_FIRST      = 0,
  parameter int CMD_LAST       = 3,
  parameter int GAP_CYCLES     = 25000000,
  parameter int TIMER_W        = 25,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ready_command,
  output logic [CMD_W-1:0] command,
  output logic             start,
  output logic             busy,
  output logic [15:0]      cmd_count,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RDY, GAP} state_t;

  localparam logic [CMD_W-1:0]   CMD_FIRST_V = CMD_W'(CMD_FIRST);
  localparam logic [CMD_W-1:0]   CMD_LAST_V  = CMD_W'(CMD_LAST);
  localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   command_q, command_d;
  logic [15:0]        count_q, count_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               wait_expired;

`ifdef CMD_SEQ_TIMEOUT_EN
  logic timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // The timer counts ready-wait cycles in both builds (saturating);
  // only the timeout action depends on the feature.
  assign wait_expired = (timer_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    command_d = command_q;
    count_d   = count_q;
    timer_d   = timer_q;
`ifdef CMD_SEQ_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable) state_d = SEND;
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (ready_command) begin
          state_d   = GAP;
          count_d   = count_q + 16'd1;
          command_d = (command_q == CMD_LAST_V) ? CMD_FIRST_V : command_q + CMD_W'(1);
          timer_d   = GAP_LOAD;
        end
`ifdef CMD_SEQ_TIMEOUT_EN
        else if (wait_expired) begin
          // Same command is re-issued after the gap.
          state_d   = GAP;
          timeout_d = 1'b1;
          timer_d   = GAP_LOAD;
        end
`endif
        else if (!wait_expired) begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = enable ? SEND : IDLE;
        else               timer_d = timer_q - TIMER_W'(1);
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      command_q <= CMD_FIRST_V;
      count_q   <= '0;
      timer_q   <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CMD_SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      command_q <= command_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
`ifdef CMD_SEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign command   = command_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign cmd_count = count_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: transaction-level model of command order,
// start-to-start spacing (1 + ack delay + gap) and acknowledged-command count.
module tb_cmd_sequencer;
  localparam int CMD_W = 2, CMD_FIRST = 1, CMD_LAST = 3, GAP = 4, TO = 8;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, ready_command = 1'b0;
  logic [CMD_W-1:0] command;
  logic start, busy, timeout;
  logic [15:0] cmd_count;
  int n_pass = 0, n_total = 0, cyc = 0;

  cmd_sequencer #(.CMD_W(CMD_W), .CMD_FIRST(CMD_FIRST), .CMD_LAST(CMD_LAST),
                  .GAP_CYCLES(GAP), .TIMER_W(25), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ready_command(ready_command),
    .command(command), .start(start), .busy(busy), .cmd_count(cmd_count),
    .timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nxt(int c);
    return (c == CMD_LAST) ? CMD_FIRST : c + 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; ready_command = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_start(input int limit, output bit ok, output int t);
    ok = 1'b0; t = -1;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin ok = 1'b1; t = cyc; end
    end
  endtask

  // Called at the negedge of the start cycle; ready is high during cycle start+d.
  // With pre set, an extra pulse lands on the start cycle itself (must be ignored).
  task automatic pulse_ready(input int d, input bit pre);
    int k;
    k = 0;
    if (pre) begin ready_command = 1'b1; @(negedge clk); ready_command = 1'b0; k = 1; end
    repeat (d - k) @(negedge clk);
    ready_command = 1'b1;
    @(negedge clk);
    ready_command = 1'b0;
  endtask

  task automatic test_reset();
    int starts, busys;
    rst = 1'b1; enable = 1'b0; ready_command = 1'b0;
    @(negedge clk);
    n_total++; if (int'(command) !== CMD_FIRST) $display("FAIL reset_command: got %0d want %0d", command, CMD_FIRST); else n_pass++;
    n_total++; if (start !== 1'b0) $display("FAIL reset_start: got %b want 0", start); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cmd_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", cmd_count); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    rst = 1'b0; starts = 0; busys = 0;
    repeat (6) begin @(negedge clk); starts += int'(start === 1'b1); busys += int'(busy !== 1'b0); end
    n_total++; if (starts + busys !== 0) $display("FAIL idle_no_enable: got %0d start/busy cycles want 0", starts + busys); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok; int t, t_prev, t_en, exp_cmd, exp_cnt;
    do_reset(); exp_cmd = CMD_FIRST; exp_cnt = 0; t_prev = 0;
    enable = 1'b1; t_en = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_start(40, ok, t);
      n_total++; if (!ok) begin $display("FAIL basic_start_seen: got none want start %0d", k); break; end else n_pass++;
      if (k == 0) begin
        n_total++; if (t - t_en !== 1) $display("FAIL basic_latency: got %0d want 1", t - t_en); else n_pass++;
      end else begin
        n_total++; if (t - t_prev !== 7) $display("FAIL basic_period: got %0d want 7", t - t_prev); else n_pass++;
      end
      n_total++; if (int'(command) !== exp_cmd) $display("FAIL basic_cmd: got %0d want %0d", command, exp_cmd); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
      t_prev = t;
      pulse_ready(2, 1'b0);
      exp_cmd = nxt(exp_cmd); exp_cnt++;
      n_total++; if (int'(cmd_count) !== exp_cnt) $display("FAIL basic_count: got %0d want %0d", cmd_count, exp_cnt); else n_pass++;
      n_total++; if (int'(command) !== exp_cmd) $display("FAIL basic_advance: got %0d want %0d", command, exp_cmd); else n_pass++;
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    bit ok; int t, t_en, starts;
    do_reset(); enable = 1'b1;
    wait_start(20, ok, t);
    pulse_ready(2, 1'b0);
    wait_start(20, ok, t);
    n_total++; if (!ok || int'(command) !== 2) $display("FAIL drop_cmd2: got %0d ok=%0b want 2", command, ok); else n_pass++;
    @(negedge clk); enable = 1'b0;
    @(negedge clk); ready_command = 1'b1;
    @(negedge clk); ready_command = 1'b0;
    n_total++; if (int'(command) !== 3 || cmd_count !== 16'd2) $display("FAIL drop_ack: got cmd %0d cnt %0d want 3/2", command, cmd_count); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL drop_gap_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL drop_idle_busy: got %b want 0", busy); else n_pass++;
    starts = 0;
    repeat (10) begin @(negedge clk); starts += int'(start === 1'b1); end
    n_total++; if (starts !== 0) $display("FAIL drop_idle_start: got %0d want 0", starts); else n_pass++;
    enable = 1'b1; t_en = cyc;
    wait_start(20, ok, t);
    n_total++; if (!ok || t - t_en !== 1 || int'(command) !== 3) $display("FAIL drop_resume: got cmd %0d lat %0d want 3/1", command, t - t_en); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_ready_held();
    bit ok; int t, t_prev, exp_cmd;
    do_reset(); ready_command = 1'b1; enable = 1'b1; exp_cmd = CMD_FIRST; t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_start(40, ok, t);
      n_total++; if (!ok || int'(command) !== exp_cmd) $display("FAIL held_cmd: got %0d want %0d", command, exp_cmd); else n_pass++;
      n_total++; if (int'(cmd_count) !== k) $display("FAIL held_count: got %0d want %0d", cmd_count, k); else n_pass++;
      if (k > 0) begin
        n_total++; if (t - t_prev !== 6) $display("FAIL held_period: got %0d want 6", t - t_prev); else n_pass++;
      end
      t_prev = t; exp_cmd = nxt(exp_cmd);
    end
    enable = 1'b0; ready_command = 1'b0;
  endtask

  task automatic test_reset_midop();
    bit ok; int t, starts;
    do_reset(); enable = 1'b1;
    wait_start(20, ok, t);
    pulse_ready(2, 1'b0);
    rst = 1'b1; #1;
    n_total++; if (int'(command) !== CMD_FIRST || cmd_count !== 16'd0 || busy !== 1'b0 || start !== 1'b0 || timeout !== 1'b0)
      $display("FAIL rst_gap: got cmd %0d cnt %0d busy %b start %b want 1/0/0/0", command, cmd_count, busy, start); else n_pass++;
    @(negedge clk); rst = 1'b0;
    wait_start(20, ok, t);
    @(negedge clk); rst = 1'b1; #1;
    n_total++; if (int'(command) !== CMD_FIRST || cmd_count !== 16'd0 || busy !== 1'b0)
      $display("FAIL rst_wait: got cmd %0d cnt %0d busy %b want 1/0/0", command, cmd_count, busy); else n_pass++;
    @(negedge clk); rst = 1'b0; enable = 1'b0;
    starts = 0;
    repeat (8) begin @(negedge clk); starts += int'(start === 1'b1); end
    n_total++; if (starts !== 0) $display("FAIL rst_needs_enable: got %0d starts want 0", starts); else n_pass++;
    enable = 1'b1;
    wait_start(20, ok, t);
    n_total++; if (!ok || int'(command) !== CMD_FIRST) $display("FAIL rst_restart_cmd: got %0d want %0d", command, CMD_FIRST); else n_pass++;
    pulse_ready(1, 1'b0);
    n_total++; if (cmd_count !== 16'd1) $display("FAIL rst_abandon_count: got %0d want 1", cmd_count); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_random();
    bit ok, pre; int t, t_prev, exp_cmd, exp_cnt, period, d;
    do_reset(); enable = 1'b1; exp_cmd = CMD_FIRST; exp_cnt = 0; t_prev = 0; period = 0;
    for (int k = 0; k < 12; k++) begin
      wait_start(60, ok, t);
      n_total++; if (!ok) begin $display("FAIL rand_start_seen: got none want start %0d", k); break; end else n_pass++;
      if (k > 0) begin
        n_total++; if (t - t_prev !== period) $display("FAIL rand_period: got %0d want %0d", t - t_prev, period); else n_pass++;
      end
      n_total++; if (int'(command) !== exp_cmd) $display("FAIL rand_cmd: got %0d want %0d", command, exp_cmd); else n_pass++;
      d = 1 + int'($urandom_range(0, 5)); pre = 1'($urandom_range(0, 1));
      pulse_ready(d, pre);
      exp_cmd = nxt(exp_cmd); exp_cnt++; period = 1 + d + GAP; t_prev = t;
      n_total++; if (int'(cmd_count) !== exp_cnt) $display("FAIL rand_count: got %0d want %0d", cmd_count, exp_cnt); else n_pass++;
    end
    enable = 1'b0;
  endtask

`ifdef CMD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen; int t, t2, t3, tt;
    do_reset(); enable = 1'b1;
    wait_start(20, ok, t);
    seen = 1'b0; tt = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin seen = 1'b1; tt = cyc; end
    end
    n_total++; if (!seen || tt - t !== TO + 1) $display("FAIL to_pulse_time: got %0d want %0d", tt - t, TO + 1); else n_pass++;
    n_total++; if (int'(command) !== CMD_FIRST || cmd_count !== 16'd0) $display("FAIL to_no_advance: got cmd %0d cnt %0d want 1/0", command, cmd_count); else n_pass++;
    @(negedge clk);
    n_total++; if (timeout !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", timeout); else n_pass++;
    wait_start(20, ok, t2);
    n_total++; if (!ok || t2 - t !== TO + 1 + GAP || int'(command) !== CMD_FIRST)
      $display("FAIL to_reissue: got cmd %0d dt %0d want 1/%0d", command, t2 - t, TO + 1 + GAP); else n_pass++;
    pulse_ready(TO, 1'b0);
    n_total++; if (timeout !== 1'b0 || cmd_count !== 16'd1 || int'(command) !== nxt(CMD_FIRST))
      $display("FAIL to_ready_wins: got to %b cnt %0d cmd %0d want 0/1/%0d", timeout, cmd_count, command, nxt(CMD_FIRST)); else n_pass++;
    wait_start(20, ok, t3);
    n_total++; if (!ok || t3 - t2 !== 1 + TO + GAP) $display("FAIL to_ready_period: got %0d want %0d", t3 - t2, 1 + TO + GAP); else n_pass++;
    enable = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    bit ok; int t, bad;
    do_reset(); enable = 1'b1;
    wait_start(20, ok, t);
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (busy !== 1'b1 || timeout !== 1'b0 || start !== 1'b0) bad++;
    end
    n_total++; if (!ok || bad !== 0) $display("FAIL no_to_wait: got %0d bad cycles ok=%0b want 0", bad, ok); else n_pass++;
    ready_command = 1'b1; @(negedge clk); ready_command = 1'b0;
    n_total++; if (cmd_count !== 16'd1) $display("FAIL no_to_late_ack: got %0d want 1", cmd_count); else n_pass++;
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_enable_drop();
    test_ready_held();
    test_reset_midop();
    test_random();
`ifdef CMD_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
